// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the RV32 pipeline hazard controller.
package pipe_ctrl_pkg;

  // Memory-wait watchdog state encoding; also visible on the debug state port.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } ctrl_state_e;

  // Architectural zero register; writes to it never create a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Synchronous clear, then increment until all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV32 pipeline: load-use bubbles,
// EX redirects, data-RAM wait freezes, memory-wait watchdog and perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_hold,
  output logic             ifid_suspend,
  output logic             ifid_flush,
  output logic             idex_suspend,
  output logic             idex_flush,
  output logic             idex_load_use,
  output logic             exmem_suspend,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  ctrl_state_e     state_q, state_d;
  logic [WC_W-1:0] wait_q, wait_d;
  logic            timeout_set;
  logic            mem_stall;
  logic            rs1_hit, rs2_hit;
  logic            lu_hit;

  assign mem_stall = mem_req & ~mem_ack;

  assign rs1_hit = id_rs1_used & (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used & (id_rs2 == ex_rd);
  assign lu_hit  = ex_valid & ex_is_load & ex_rf_we & (ex_rd != REG_ZERO) &
                   id_valid & (rs1_hit | rs2_hit);

  assign state = state_q;

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_timeout <= mem_timeout | timeout_set;
    end
  end

  // Watchdog next state: count consecutive stalled cycles, trap at the limit.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    timeout_set = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = ST_ERR;
          timeout_set = 1'b1;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Priority mux for pipeline controls: error > RAM wait > redirect > load-use.
  always_comb begin
    pc_hold       = 1'b0;
    ifid_suspend  = 1'b0;
    ifid_flush    = 1'b0;
    idex_suspend  = 1'b0;
    idex_flush    = 1'b0;
    idex_load_use = 1'b0;
    exmem_suspend = 1'b0;
    memwb_flush   = 1'b0;
    if (!cpu_rst) begin
      if ((state_q == ST_ERR) || mem_stall) begin
        // EX is frozen, so a pending redirect stays stable until the ack cycle.
        pc_hold       = 1'b1;
        ifid_suspend  = 1'b1;
        idex_suspend  = 1'b1;
        exmem_suspend = 1'b1;
        memwb_flush   = 1'b1;
      end else if (ex_redirect) begin
        // ID holds a wrong-path instruction, so any load-use hit is moot.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu_hit) begin
        pc_hold       = 1'b1;
        ifid_suspend  = 1'b1;
        idex_load_use = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (cpu_clk),
    .rst (cpu_rst),
    .inc (pc_hold),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (cpu_clk),
    .rst (cpu_rst),
    .inc (ifid_flush),
    .q   (flush_events)
  );

endmodule
